instr_fetch: RTL and testbench

Instruction fetch stage of the RISC-V core, upstream of `UnidadControl`. It keeps the fetch PC, runs a request/acknowledge transaction with instruction memory, and latches each returned word in an instruction register. It presents `opcode`/`funct3`/`funct7` and the register fields to the control unit and datapath. It also takes pipeline stalls and PC redirects for JAL, JALR and taken branches.

---
 rtl/instr_fetch.sv | 104 ++++++++++
 tb/tb_instr_fetch.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch: holds the fetch PC, runs one req/ack memory transaction at a time, latches the word into an instruction register.
// Latency: instr_valid rises one cycle after the ack edge; at best one instruction every 2 cycles.
// Backpressure: stall keeps the instruction in HOLD; a redirect preempts it, and a stale transaction is drained and discarded.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] pend_pc;
    logic [31:0] redirect_tgt;

    assign redirect_tgt = redirect_pc & ~32'h3;

    // A request is never presented while reset is asserted, even mid-transaction.
    assign imem_req  = rst_n && ((state == FETCH) || (state == DRAIN));
    assign imem_addr = fetch_pc;

    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign funct3   = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign funct7   = instr[31:25];
    assign pc_plus4 = pc_out + 32'd4;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            pend_pc     <= RESET_PC;
            instr       <= NOP;
            pc_out      <= RESET_PC;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= FETCH;

                FETCH: begin
                    if (imem_ack && redirect_valid) begin
                        fetch_pc <= redirect_tgt;
                    end else if (imem_ack) begin
                        instr       <= imem_rdata;
                        pc_out      <= fetch_pc;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end else if (redirect_valid) begin
                        // The request cannot be withdrawn; let it finish and drop its data.
                        pend_pc <= redirect_tgt;
                        state   <= DRAIN;
                    end
                end

                DRAIN: begin
                    if (imem_ack) begin
                        fetch_pc <= redirect_valid ? redirect_tgt : pend_pc;
                        state    <= FETCH;
                    end else if (redirect_valid) begin
                        pend_pc <= redirect_tgt;
                    end
                end

                HOLD: begin
                    if (redirect_valid) begin
                        instr_valid <= 1'b0;
                        fetch_pc    <= redirect_tgt;
                        state       <= FETCH;
                    end else if (!stall) begin
                        instr_valid <= 1'b0;
                        fetch_pc    <= pc_out + 32'd4;
                        state       <= FETCH;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: transaction-level reference model feeding expected requests and deliveries into queues checked by a monitor.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2),
        .pc_out(pc_out), .pc_plus4(pc_plus4)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_deliv  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h0000_0000: memf = 32'h0000_0033;
            32'h0000_0004: memf = 32'h4000_0033;
            32'h0000_0008: memf = 32'h0000_2083;
            32'h0000_0010: memf = 32'h0000_006F;
            default:       memf = (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    // ---------------- memory responder ----------------
    int cfg_wait = 0;   // negative: random 0..3 wait cycles per transaction
    bit mem_busy = 0;
    int mem_w = 0;
    bit last_hs = 0;

    always @(posedge clk) begin
        #1;
        if (!imem_req || last_hs) mem_busy = 0;
        if (imem_req) begin
            if (!mem_busy) begin
                mem_busy = 1;
                mem_w = (cfg_wait < 0) ? int'($urandom_range(0, 3)) : cfg_wait;
            end
            imem_ack = (mem_w == 0);
            if (mem_w > 0) mem_w--;
            imem_rdata = imem_ack ? memf(imem_addr) : $urandom();
        end else begin
            // Spurious acks without a request must be ignored.
            imem_ack   = ($urandom_range(0, 3) == 0);
            imem_rdata = $urandom();
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] addr_q[$];
    logic [31:0] pc_q[$];
    logic [31:0] ins_q[$];
    logic [31:0] seen_addr[$];

    bit          m_started, m_txn, m_stale, m_hold;
    logic [31:0] m_txn_pc, m_next, m_hold_pc;

    task start_txn(input logic [31:0] a);
        m_txn    = 1;
        m_stale  = 0;
        m_txn_pc = a;
        addr_q.push_back(a);
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_started = 0; m_txn = 0; m_stale = 0; m_hold = 0;
            m_next = RESET_PC; last_hs = 0;
            addr_q.delete(); pc_q.delete(); ins_q.delete();
        end else begin
            last_hs = imem_req && imem_ack;
            if (!m_started) begin
                m_started = 1;
                start_txn(m_next);
            end else if (m_txn) begin
                if (imem_ack) begin
                    if (redirect_valid)  start_txn(redirect_pc & ~32'h3);
                    else if (m_stale)    start_txn(m_next);
                    else begin
                        m_txn = 0; m_hold = 1; m_hold_pc = m_txn_pc;
                        pc_q.push_back(m_txn_pc);
                        ins_q.push_back(memf(m_txn_pc));
                    end
                end else if (redirect_valid) begin
                    m_stale = 1;
                    m_next  = redirect_pc & ~32'h3;
                end
            end else if (m_hold) begin
                if (redirect_valid) begin
                    m_hold = 0; start_txn(redirect_pc & ~32'h3);
                end else if (!stall) begin
                    m_hold = 0; start_txn(m_hold_pc + 32'd4);
                end
            end
        end
    end

    // ---------------- monitor ----------------
    bit          p_req = 0, p_hs = 0, p_vld = 0;
    logic [31:0] p_addr = 32'h0;

    always @(negedge clk) begin
        logic [31:0] e_pc, e_ins;
        check("req_while_valid", imem_req & instr_valid, 1'b0);
        if (imem_req) begin
            check("addr_align", {30'h0, imem_addr[1:0]}, 32'h0);
            if (!p_req || p_hs) begin
                seen_addr.push_back(imem_addr);
                check("addr_expected", addr_q.size() != 0, 1'b1);
                if (addr_q.size() != 0) check("req_addr", imem_addr, addr_q.pop_front());
            end else begin
                check("addr_stable", imem_addr, p_addr);
            end
        end
        if (instr_valid && !p_vld) begin
            n_deliv++;
            check("deliv_expected", pc_q.size() != 0, 1'b1);
            if (pc_q.size() != 0) begin
                e_pc  = pc_q.pop_front();
                e_ins = ins_q.pop_front();
                check("instr", instr, e_ins);
                check("pc_out", pc_out, e_pc);
                check("pc_plus4", pc_plus4, e_pc + 32'd4);
                check("opcode", {25'h0, opcode}, {25'h0, e_ins[6:0]});
                check("funct3", {29'h0, funct3}, {29'h0, e_ins[14:12]});
                check("funct7", {25'h0, funct7}, {25'h0, e_ins[31:25]});
                check("rd",  {27'h0, rd},  {27'h0, e_ins[11:7]});
                check("rs1", {27'h0, rs1}, {27'h0, e_ins[19:15]});
                check("rs2", {27'h0, rs2}, {27'h0, e_ins[24:20]});
            end
        end
        p_req  = imem_req;
        p_hs   = imem_req && imem_ack;
        p_vld  = instr_valid;
        p_addr = imem_addr;
    end

    // ---------------- directed + random stimulus ----------------
    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic wait_deliv(input int n);
        int t = 0;
        while (n_deliv < n && t < 300) begin tick(); t++; end
        check("deliv_wait", n_deliv >= n, 1'b1);
    endtask

    task automatic wait_seen(input int n);
        int t = 0;
        while (seen_addr.size() < n && t < 300) begin tick(); t++; end
        check("req_wait", seen_addr.size() >= n, 1'b1);
    endtask

    task automatic consume();
        stall = 1'b0;
        tick();
        stall = 1'b1;
    endtask

    initial begin
        int s0;
        repeat (3) tick();
        check("rst_req", imem_req, 1'b0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_opcode", {25'h0, opcode}, 32'h13);
        check("rst_fields", {funct3, funct7, rd, rs1, rs2}, 32'h0);
        check("rst_pc_out", pc_out, RESET_PC);
        rst_n = 1'b1;
        #1;
        check("idle_req", imem_req, 1'b0);
        tick();
        check("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, RESET_PC);

        // sequential zero-wait fetch
        wait_deliv(1);
        check("add_opcode", {25'h0, opcode}, 32'h33);
        check("add_funct7", {25'h0, funct7}, 32'h0);
        check("add_pc", pc_out, 32'h0);
        consume();
        wait_deliv(2);
        check("sub_funct7", {25'h0, funct7}, 32'h20);
        check("sub_pc", pc_out, 32'h4);
        consume();
        wait_deliv(3);
        check("seq_addr_count", seen_addr.size(), 32'd3);
        if (seen_addr.size() >= 3) begin
            check("seq_addr0", seen_addr[0], 32'h0);
            check("seq_addr1", seen_addr[1], 32'h4);
            check("seq_addr2", seen_addr[2], 32'h8);
        end

        // stall holds LW
        repeat (5) begin
            tick();
            check("stall_valid", instr_valid, 1'b1);
            check("stall_funct3", {29'h0, funct3}, 32'h2);
            check("stall_req", imem_req, 1'b0);
        end
        stall = 1'b0;
        tick();
        stall = 1'b1;
        check("unstall_req", imem_req, 1'b1);
        check("unstall_addr", imem_addr, 32'hC);
        check("unstall_valid", instr_valid, 1'b0);

        // redirect in HOLD
        wait_deliv(4);
        consume();
        wait_deliv(5);
        check("jal_opcode", {25'h0, opcode}, 32'h6F);
        check("jal_pc", pc_out, 32'h10);
        cfg_wait = 3;
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        tick();
        redirect_valid = 1'b0;
        check("hold_redir_valid", instr_valid, 1'b0);
        check("hold_redir_req", imem_req, 1'b1);
        check("hold_redir_addr", imem_addr, 32'h100);

        // redirects during wait states
        wait_deliv(6);
        s0 = seen_addr.size();
        consume();
        check("drain_start", seen_addr.size(), s0 + 1);
        check("drain_old_addr", imem_addr, 32'h104);
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect_pc = 32'h300;
        tick();
        redirect_valid = 1'b0;
        wait_seen(s0 + 2);
        if (seen_addr.size() >= s0 + 2) check("drain_next_addr", seen_addr[s0 + 1], 32'h300);
        check("drain_no_valid", n_deliv, 32'd6);

        // reset in the middle of a transaction
        tick();
        rst_n = 1'b0;
        tick();
        check("mid_rst_req", imem_req, 1'b0);
        check("mid_rst_valid", instr_valid, 1'b0);
        check("mid_rst_instr", instr, 32'h0000_0013);
        rst_n = 1'b1;

        // wrap-around
        wait_deliv(7);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        wait_deliv(8);
        check("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", pc_plus4, 32'h0);
        consume();
        check("wrap_req", imem_req, 1'b1);
        check("wrap_addr", imem_addr, 32'h0);

        // randomized traffic
        cfg_wait = -1;
        s0 = n_deliv;
        for (int i = 0; i < 3000; i++) begin
            tick();
            stall          = ($urandom_range(0, 1) == 1);
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_pc    = $urandom();
            rst_n          = ($urandom_range(0, 399) != 0);
        end
        tick();
        rst_n = 1'b1;
        redirect_valid = 1'b0;
        stall = 1'b0;
        repeat (20) tick();
        check("addr_q_drained", addr_q.size(), 32'd0);
        check("deliv_q_drained", pc_q.size(), 32'd0);
        check("random_progress", (n_deliv - s0) > 200, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion, expected finish");
        $fatal(1, "timeout");
    end

endmodule
